// File: rtl/tmnt_snd_pkg.sv
// -----------------------------------------------------------------------------
// tmnt_snd_pkg
// Shared constants and helpers for the TMNT 68000 -> Z80 sound bridge.
//   ACC_W_DEF   : default phase accumulator width
//   calc_inc()  : phase increment for a target rate from a given clock
//   FIFO_DEPTH  : sound-command FIFO depth (TMNT_SNDLATCH_FIFO_EN build)
//   FIFO_PTR_W  : FIFO pointer width
// -----------------------------------------------------------------------------
package tmnt_snd_pkg;

    localparam int unsigned ACC_W_DEF  = 24;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_PTR_W = 2;

    typedef logic [7:0] snd_code_t;

    // round(target_hz * 2^acc_w / clk_hz)
    function automatic longint unsigned calc_inc(
        input longint unsigned clk_hz,
        input longint unsigned target_hz,
        input int unsigned     acc_w
    );
        return ((target_hz << acc_w) + (clk_hz / 2)) / clk_hz;
    endfunction

endpackage

// File: rtl/tmnt_frac_ce.sv
// -----------------------------------------------------------------------------
// tmnt_frac_ce
// Fractional clock-enable generator: a phase accumulator advanced by INC each
// clock; the registered carry out is a one-cycle enable whose long-run rate is
// INC / 2^ACC_W of the clock. The residue stays in the accumulator, so there is
// no cumulative drift.
// Ports:
//   clk_main : system clock
//   reset    : asynchronous, active-high reset
//   ce       : single-cycle enable pulse
// -----------------------------------------------------------------------------
module tmnt_frac_ce #(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned INC   = 2502283
) (
    input  logic clk_main,
    input  logic reset,
    output logic ce
);

    localparam logic [ACC_W-1:0] INC_V = ACC_W'(INC);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ce_q,  ce_d;
    logic [ACC_W:0]   sum;

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, INC_V};
        acc_d = sum[ACC_W-1:0];
        ce_d  = sum[ACC_W];
    end

    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ce_q  <= ce_d;
        end
    end

    assign ce = ce_q;

endmodule

// File: rtl/tmnt_sound_if.sv
// -----------------------------------------------------------------------------
// tmnt_sound_if
// Bridge between the 68000 main board and the Z80 sound subsystem.
//   - Z80 (3.58 MHz) and 640 kHz clock enables from clk_main.
//   - Sound code captured from cpu_dout during the SNDDT strobe and committed
//     on its rising edge.
//   - SNDON rising edge raises a Z80 interrupt held until acknowledged.
// Optional build macro: TMNT_SNDLATCH_FIFO_EN replaces the single sound latch
// with a 4-entry command FIFO and enables the sticky snd_ovf flag.
// Ports:
//   clk_main     in   system clock (24 MHz)
//   reset        in   asynchronous, active-high reset
//   snd_wr_n     in   SNDDT strobe, active low
//   snd_on       in   SNDON level
//   cpu_dout     in   68k data bus low byte
//   z80_ce       out  Z80 clock enable
//   ce_640k      out  640 kHz enable
//   z80_latch_rd in   Z80 read of sound-code port (qualified by z80_ce)
//   z80_iack     in   Z80 interrupt acknowledge (qualified by z80_ce)
//   z80_din      out  sound code to Z80
//   z80_int_n    out  Z80 INT, active low
//   snd_ovf      out  sticky FIFO overflow (0 in single-latch build)
// -----------------------------------------------------------------------------
module tmnt_sound_if
    import tmnt_snd_pkg::*;
#(
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int unsigned Z80_INC = 2502283,
    parameter int unsigned SND_INC = 447392
) (
    input  logic       clk_main,
    input  logic       reset,
    input  logic       snd_wr_n,
    input  logic       snd_on,
    input  logic [7:0] cpu_dout,
    output logic       z80_ce,
    output logic       ce_640k,
    input  logic       z80_latch_rd,
    input  logic       z80_iack,
    output logic [7:0] z80_din,
    output logic       z80_int_n,
    output logic       snd_ovf
);

    // ------------------------------------------------------------------ enables
    tmnt_frac_ce #(
        .ACC_W (ACC_W),
        .INC   (Z80_INC)
    ) u_z80_ce (
        .clk_main (clk_main),
        .reset    (reset),
        .ce       (z80_ce)
    );

    tmnt_frac_ce #(
        .ACC_W (ACC_W),
        .INC   (SND_INC)
    ) u_snd_ce (
        .clk_main (clk_main),
        .reset    (reset),
        .ce       (ce_640k)
    );

    // ------------------------------------------------------- strobe / edge regs
    logic      wr_s1_q, wr_s1_d;
    logic      wr_s2_q, wr_s2_d;
    logic      on_s1_q, on_s1_d;
    logic      on_s2_q, on_s2_d;
    snd_code_t hold_q,  hold_d;
    logic      irq_pend_q, irq_pend_d;

    logic commit;
    logic on_edge;
    logic iack_ce;

    always_comb begin
        wr_s1_d = snd_wr_n;
        wr_s2_d = wr_s1_q;
        on_s1_d = snd_on;
        on_s2_d = on_s1_q;
        hold_d  = snd_wr_n ? hold_q : cpu_dout;

        commit  = wr_s1_q & ~wr_s2_q;
        on_edge = on_s1_q & ~on_s2_q;
        iack_ce = z80_iack & z80_ce;

        // A new edge wins over a simultaneous acknowledge.
        irq_pend_d = on_edge | (irq_pend_q & ~iack_ce);
    end

    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            wr_s1_q    <= 1'b1;
            wr_s2_q    <= 1'b1;
            on_s1_q    <= 1'b0;
            on_s2_q    <= 1'b0;
            hold_q     <= '0;
            irq_pend_q <= 1'b0;
        end else begin
            wr_s1_q    <= wr_s1_d;
            wr_s2_q    <= wr_s2_d;
            on_s1_q    <= on_s1_d;
            on_s2_q    <= on_s2_d;
            hold_q     <= hold_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    assign z80_int_n = ~irq_pend_q;

`ifdef TMNT_SNDLATCH_FIFO_EN
    // --------------------------------------------------------- command FIFO
    localparam logic [FIFO_PTR_W:0] FULL_CNT = (FIFO_PTR_W + 1)'(FIFO_DEPTH);

    logic [FIFO_DEPTH-1:0][7:0] mem_q,    mem_d;
    logic [FIFO_PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [FIFO_PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [FIFO_PTR_W:0]        count_q,  count_d;
    snd_code_t                  last_q,   last_d;
    logic                       ovf_q,    ovf_d;

    logic do_pop;
    logic do_push;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        last_d   = last_q;
        ovf_d    = ovf_q;

        do_pop  = z80_latch_rd & z80_ce & (count_q != '0);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_push = commit & ((count_q != FULL_CNT) | do_pop);

        if (do_pop) begin
            last_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push) begin
            mem_d[wr_ptr_q] = hold_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (commit & ~do_push) begin
            ovf_d = 1'b1;
        end

        count_d = count_q + {{FIFO_PTR_W{1'b0}}, do_push}
                          - {{FIFO_PTR_W{1'b0}}, do_pop};
    end

    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
        end
    end

    // Empty FIFO keeps presenting the most recently popped byte.
    assign z80_din = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;
    assign snd_ovf = ovf_q;

`else
    // --------------------------------------------------------- single latch
    snd_code_t din_q, din_d;
    logic      unused_rd;

    always_comb begin
        din_d = commit ? hold_q : din_q;
    end

    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            din_q <= '0;
        end else begin
            din_q <= din_d;
        end
    end

    // Z80 reads are non-destructive on a plain latch.
    assign unused_rd = z80_latch_rd;
    assign z80_din   = din_q;
    assign snd_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_tmnt_sound_if.sv
// -----------------------------------------------------------------------------
// tb_tmnt_sound_if
// Directed self-checking bench for tmnt_sound_if. Covers both builds; compile
// with +define+TMNT_SNDLATCH_FIFO_EN to exercise the command FIFO.
// -----------------------------------------------------------------------------
module tb_tmnt_sound_if;

    localparam int unsigned ACC_W   = 24;
    localparam int unsigned Z80_INC = 2502283;
    localparam int unsigned SND_INC = 447392;

    logic       clk_main = 1'b0;
    logic       reset;
    logic       snd_wr_n;
    logic       snd_on;
    logic [7:0] cpu_dout;
    logic       z80_ce;
    logic       ce_640k;
    logic       z80_latch_rd;
    logic       z80_iack;
    logic [7:0] z80_din;
    logic       z80_int_n;
    logic       snd_ovf;

    int n_assert = 0;
    int n_fail   = 0;

    tmnt_sound_if #(
        .ACC_W   (ACC_W),
        .Z80_INC (Z80_INC),
        .SND_INC (SND_INC)
    ) dut (
        .clk_main     (clk_main),
        .reset        (reset),
        .snd_wr_n     (snd_wr_n),
        .snd_on       (snd_on),
        .cpu_dout     (cpu_dout),
        .z80_ce       (z80_ce),
        .ce_640k      (ce_640k),
        .z80_latch_rd (z80_latch_rd),
        .z80_iack     (z80_iack),
        .z80_din      (z80_din),
        .z80_int_n    (z80_int_n),
        .snd_ovf      (snd_ovf)
    );

    always #5 clk_main = ~clk_main;

    // Reference phase accumulator for the Z80 enable, used to line up an
    // SNDON edge with a known z80_ce cycle.
    logic [23:0] acc_m;
    logic [24:0] acc_next;
    always @(posedge clk_main or posedge reset) begin
        if (reset) acc_m <= 24'd0;
        else       acc_m <= acc_m + 24'(Z80_INC);
    end
    assign acc_next = {1'b0, acc_m} + 25'(Z80_INC);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves the strobe risen at a negedge.
    task automatic write_byte(input logic [7:0] d, input int ncyc);
        snd_wr_n = 1'b0;
        cpu_dout = d;
        repeat (ncyc) @(negedge clk_main);
        snd_wr_n = 1'b1;
        cpu_dout = 8'hFF;
    endtask

    // Called at a negedge; pulses iack (sel=1) or latch_rd (sel=0) on a
    // z80_ce cycle and returns 1 time unit after the sampling posedge.
    task automatic pulse_on_ce(input bit sel, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (z80_ce === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk_main);
        end
        chk({tag, "_ce_seen"}, {31'd0, found}, 32'd1);
        if (sel) z80_iack = 1'b1;
        else     z80_latch_rd = 1'b1;
        @(posedge clk_main);
        #1;
        z80_iack     = 1'b0;
        z80_latch_rd = 1'b0;
    endtask

    initial begin
        int  cnt_z80, cnt_snd, b2b_z80, b2b_snd;
        bit  prev_z80, prev_snd, found;

        reset        = 1'b1;
        snd_wr_n     = 1'b1;
        snd_on       = 1'b0;
        cpu_dout     = 8'h00;
        z80_latch_rd = 1'b0;
        z80_iack     = 1'b0;

        // ---------------------------------------------------------- reset state
        repeat (3) @(negedge clk_main);
        chk("rst_z80_ce",    {31'd0, z80_ce},    32'd0);
        chk("rst_ce_640k",   {31'd0, ce_640k},   32'd0);
        chk("rst_z80_din",   {24'd0, z80_din},   32'h00);
        chk("rst_z80_int_n", {31'd0, z80_int_n}, 32'd1);
        chk("rst_snd_ovf",   {31'd0, snd_ovf},   32'd0);
        reset = 1'b0;

        // ------------------------------------------------------------ rate check
        // 50000 cycles: 7457.38 Z80 enables and 1333.33 640k enables expected.
        cnt_z80 = 0; cnt_snd = 0; b2b_z80 = 0; b2b_snd = 0;
        prev_z80 = 1'b0; prev_snd = 1'b0;
        for (int i = 0; i < 50000; i++) begin
            @(negedge clk_main);
            if (z80_ce)  cnt_z80++;
            if (ce_640k) cnt_snd++;
            if (z80_ce && prev_z80)  b2b_z80++;
            if (ce_640k && prev_snd) b2b_snd++;
            prev_z80 = z80_ce;
            prev_snd = ce_640k;
        end
        chk($sformatf("z80_rate_cnt_%0d", cnt_z80),
            {31'd0, (cnt_z80 >= 7456 && cnt_z80 <= 7458)}, 32'd1);
        chk($sformatf("snd_rate_cnt_%0d", cnt_snd),
            {31'd0, (cnt_snd >= 1332 && cnt_snd <= 1334)}, 32'd1);
        chk("z80_no_back_to_back", b2b_z80, 32'd0);
        chk("snd_no_back_to_back", b2b_snd, 32'd0);

        // ---------------------------------------------------------------- latch
        write_byte(8'h5A, 3);
        @(negedge clk_main);
        chk("latch_5a_not_yet", {24'd0, z80_din}, 32'h00);
        @(negedge clk_main);
        chk("latch_5a_2cyc", {24'd0, z80_din}, 32'h5A);
`ifdef TMNT_SNDLATCH_FIFO_EN
        pulse_on_ce(1'b0, "pop_5a");
        chk("fifo_empty_keeps_5a", {24'd0, z80_din}, 32'h5A);
        @(negedge clk_main);
`else
        pulse_on_ce(1'b0, "rd_5a");
        chk("latch_rd_no_effect", {24'd0, z80_din}, 32'h5A);
        @(negedge clk_main);
`endif
        write_byte(8'h3C, 1);
        @(negedge clk_main);
        @(negedge clk_main);
        chk("latch_3c_1cyc_strobe", {24'd0, z80_din}, 32'h3C);

        // ------------------------------------------------------------------ IRQ
        snd_on = 1'b1;
        @(negedge clk_main);
        chk("irq_not_yet", {31'd0, z80_int_n}, 32'd1);
        @(negedge clk_main);
        chk("irq_asserted_2cyc", {31'd0, z80_int_n}, 32'd0);
        pulse_on_ce(1'b1, "ack1");
        chk("irq_cleared_next", {31'd0, z80_int_n}, 32'd1);
        repeat (10) @(negedge clk_main);
        chk("irq_level_no_reraise", {31'd0, z80_int_n}, 32'd1);

        // Two edges before the ack merge into a single request.
        snd_on = 1'b0;
        repeat (2) @(negedge clk_main);
        snd_on = 1'b1;
        repeat (3) @(negedge clk_main);
        snd_on = 1'b0;
        repeat (2) @(negedge clk_main);
        snd_on = 1'b1;
        repeat (3) @(negedge clk_main);
        snd_on = 1'b0;
        chk("irq_merge_pending", {31'd0, z80_int_n}, 32'd0);
        pulse_on_ce(1'b1, "ack2");
        chk("irq_merge_cleared", {31'd0, z80_int_n}, 32'd1);
        repeat (5) @(negedge clk_main);
        chk("irq_merge_no_second", {31'd0, z80_int_n}, 32'd1);

        // ------------------------------------------------ same-cycle set / clear
        snd_on = 1'b1;
        repeat (3) @(negedge clk_main);
        snd_on = 1'b0;
        chk("sc_pending_before", {31'd0, z80_int_n}, 32'd0);
        repeat (2) @(negedge clk_main);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (acc_next[24]) begin
                found = 1'b1;
                break;
            end
            @(negedge clk_main);
        end
        chk("sc_ce_predicted", {31'd0, found}, 32'd1);
        snd_on = 1'b1;
        @(negedge clk_main);
        chk("sc_ce_at_iack", {31'd0, z80_ce}, 32'd1);
        z80_iack = 1'b1;
        @(posedge clk_main);
        #1;
        z80_iack = 1'b0;
        chk("sc_set_wins", {31'd0, z80_int_n}, 32'd0);
        @(negedge clk_main);
        chk("sc_still_pending", {31'd0, z80_int_n}, 32'd0);

        // ------------------------------------------------------ reset mid-op
        snd_on   = 1'b0;
        snd_wr_n = 1'b0;
        cpu_dout = 8'h77;
        @(negedge clk_main);
        reset = 1'b1;
        #1;
        chk("midrst_int_n", {31'd0, z80_int_n}, 32'd1);
        chk("midrst_din",   {24'd0, z80_din},   32'h00);
        snd_wr_n = 1'b1;
        @(negedge clk_main);
        reset = 1'b0;
        repeat (4) @(negedge clk_main);
        chk("midrst_no_commit", {24'd0, z80_din},   32'h00);
        chk("midrst_no_irq",    {31'd0, z80_int_n}, 32'd1);
        write_byte(8'hAA, 1);
        @(negedge clk_main);
        @(negedge clk_main);
        chk("post_rst_write", {24'd0, z80_din}, 32'hAA);

`ifdef TMNT_SNDLATCH_FIFO_EN
        // ---------------------------------------------------------------- FIFO
        pulse_on_ce(1'b0, "pop_aa");
        chk("fifo_empty_keeps_aa", {24'd0, z80_din}, 32'hAA);
        @(negedge clk_main);
        for (int b = 1; b <= 5; b++) begin
            write_byte(8'(b), 1);
            @(negedge clk_main);
        end
        repeat (2) @(negedge clk_main);
        chk("fifo_ovf_set",  {31'd0, snd_ovf}, 32'd1);
        chk("fifo_head_01",  {24'd0, z80_din}, 32'h01);
        pulse_on_ce(1'b0, "pop1");
        chk("fifo_head_02",  {24'd0, z80_din}, 32'h02);
        @(negedge clk_main);
        pulse_on_ce(1'b0, "pop2");
        chk("fifo_head_03",  {24'd0, z80_din}, 32'h03);
        @(negedge clk_main);
        pulse_on_ce(1'b0, "pop3");
        chk("fifo_head_04",  {24'd0, z80_din}, 32'h04);
        @(negedge clk_main);
        pulse_on_ce(1'b0, "pop4");
        chk("fifo_empty_04", {24'd0, z80_din}, 32'h04);
        @(negedge clk_main);
        pulse_on_ce(1'b0, "pop_empty");
        chk("fifo_pop_empty_04", {24'd0, z80_din}, 32'h04);
        chk("fifo_ovf_sticky",   {31'd0, snd_ovf}, 32'd1);
`else
        chk("ovf_tied_low", {31'd0, snd_ovf}, 32'd0);
`endif

        repeat (2) @(negedge clk_main);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
